alu_cmd_parser: RTL and testbench
=================================

Name: alu_cmd_parser

Overview:
Command parser between the UART byte receiver and the ALU datapath. It consumes received bytes (value/data_valid), parses ASCII commands of the form "<A><op><B><term>", and drives registered operands A, B and a 2-bit operator to the add/sub/mul/div units and result mux. Malformed commands are rejected without disturbing the last valid operands. An inter-byte timeout aborts stalled commands.

Parameters:
MAX_DIGITS, 3, maximum decimal digits per operand
TIMEOUT_CYCLES, 50_000_000, clk cycles of byte silence that abort an in-progress command; 0 disables the timeout

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
value  input  8  received byte from UART receiver
data_valid  input  1  one-cycle strobe; value is valid this cycle
A  output  8  operand A, held until the next valid command
B  output  8  operand B, held until the next valid command
operator  output  2  00 add, 01 sub, 10 mul, 11 div; held
cmd_valid  output  1  one-cycle pulse when A/B/operator update
cmd_err  output  1  one-cycle pulse on rejected or timed-out command
busy  output  1  high while a command is in progress (state != S_IDLE)

Behaviour:
- Reset (rst=0, async): A=0, B=0, operator=00, cmd_valid=0, cmd_err=0, busy=0, state S_IDLE, accumulators/digit counts/timeout counter cleared. Reset mid-command discards the partial command.
- Byte classes: digit 0x30-0x39; operator '+' (0x2B)->00, '-' (0x2D)->01, '*' (0x2A)->10, '/' (0x2F)->11; terminator '=' (0x3D) or CR (0x0D); space (0x20) ignored in every state; LF (0x0A) ignored; anything else is illegal.
- Only cycles with data_valid=1 advance the FSM. At most one byte per cycle.
- States:
  S_IDLE: digit -> load acc_a=digit, cnt_a=1, go S_A; terminator -> stay (blank line, no error); operator or illegal -> S_ERR.
  S_A: digit -> acc_a=acc_a*10+digit, cnt_a+1; operator -> latch op, go S_B; terminator or illegal -> S_ERR.
  S_B: digit -> acc_b=acc_b*10+digit, cnt_b+1; terminator with cnt_b>=1 -> commit, go S_IDLE; terminator with cnt_b=0, operator, or illegal -> S_ERR.
  S_ERR: discard bytes until a terminator, then pulse cmd_err and go S_IDLE.
- Range: the product acc*10+digit is computed at least 12 bits wide. A result >255, or a digit that would make the count exceed MAX_DIGITS, -> S_ERR. Leading zeros count as digits.
- Commit: terminator sampled in cycle N -> A, B and operator updated, and cmd_valid=1, in cycle N+1. cmd_valid and cmd_err are never high in the same cycle.
- On error, A, B and operator are unchanged.
- Timeout: counter clears on every data_valid and in S_IDLE. In S_A, S_B or S_ERR, reaching TIMEOUT_CYCLES-1 idle cycles -> next cycle cmd_err=1, state S_IDLE. If a byte arrives in that same cycle, the byte wins and the timeout does not fire.
- No division-by-zero check here; B=0 is a legal command.

Optional Feature:
ALU_CMD_STICKY_ERR_EN: when defined, cmd_err becomes a level. It is set on any error or timeout and stays high until the next successful commit, where it clears in the same cycle cmd_valid pulses. This lets an LED show a stale/bad command. When undefined, cmd_err is a one-cycle pulse as above.

Test Plan:
1. Bytes "12+34=" -> cycle after '=': A=12, B=34, operator=00, cmd_valid high exactly 1 cycle, busy=0.
2. "255*2\r" then "9-3=" -> first commit A=255, B=2, op=10; second A=9, B=3, op=01.
3. Prime with "12+34=", then send "256+1=" and "1234+1=" -> each gives one cmd_err pulse after '='; A=12, B=34 and op=00 are retained; no cmd_valid.
4. " 7 / 0 =" and "5+=" and "+3=" -> first commits A=7, B=0, op=11; the others each pulse cmd_err.
5. TIMEOUT_CYCLES=100: "5+" then 100 idle cycles -> cmd_err pulse, busy=0; then "1-1=" -> A=1, B=1, op=01.
6. "12+" then rst low 2 cycles -> all outputs 0; then "3*4=" -> A=3, B=4, op=10. With ALU_CMD_STICKY_ERR_EN, re-run 3 then 1: cmd_err stays high until the commit cycle.

Source files
------------

// File: rtl/alu_cmd_parser.sv
// rtl/alu_cmd_parser.sv - ASCII "<A><op><B><term>" command parser feeding the ALU operand registers
// Optional build macro: ALU_CMD_STICKY_ERR_EN (cmd_err held as a level until the next good commit)
module alu_cmd_parser #(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       data_valid,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [1:0] operator,
    output logic       cmd_valid,
    output logic       cmd_err,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_A, S_B, S_ERR} state_t;

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] T_LAST  = (TIMEOUT_CYCLES > 1) ? TW'(TIMEOUT_CYCLES - 1) : '0;

`ifdef ALU_CMD_STICKY_ERR_EN
    localparam bit STICKY_ERR = 1'b1;
`else
    localparam bit STICKY_ERR = 1'b0;
`endif

    state_t          state;
    logic [7:0]      acc_a;
    logic [7:0]      acc_b;
    logic [CW-1:0]   cnt_a;
    logic [CW-1:0]   cnt_b;
    logic [1:0]      op_pend;
    logic [TW-1:0]   tcnt;

    logic            is_digit;
    logic            is_term;
    logic            is_skip;
    logic            is_op;
    logic [1:0]      op_code;
    logic [11:0]     prod_a;
    logic [11:0]     prod_b;
    logic            a_ok;
    logic            b_ok;
    logic            tmo_hit;

    assign busy = (state != S_IDLE);

    // Classify the incoming byte and precompute the next accumulator values and their legality
    always_comb begin
        is_digit = (value >= 8'h30) && (value <= 8'h39);
        is_term  = (value == 8'h3D) || (value == 8'h0D);
        is_skip  = (value == 8'h20) || (value == 8'h0A);
        is_op    = 1'b1;
        op_code  = 2'b00;
        case (value)
            8'h2B:   op_code = 2'b00;
            8'h2D:   op_code = 2'b01;
            8'h2A:   op_code = 2'b10;
            8'h2F:   op_code = 2'b11;
            default: is_op   = 1'b0;
        endcase
        // 12 bits hold 255*10+9 without wrap, so the >255 check is exact
        prod_a  = {4'b0, acc_a} * 12'd10 + {8'b0, value[3:0]};
        prod_b  = {4'b0, acc_b} * 12'd10 + {8'b0, value[3:0]};
        a_ok    = (prod_a <= 12'd255) && (cnt_a != CNT_MAX);
        b_ok    = (prod_b <= 12'd255) && (cnt_b != CNT_MAX);
        tmo_hit = (TIMEOUT_CYCLES != 0) && (state != S_IDLE) && !data_valid && (tcnt == T_LAST);
    end

    // Parser FSM with registered operand outputs, status pulses and inter-byte timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            acc_a     <= '0;
            acc_b     <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            op_pend   <= 2'b00;
            tcnt      <= '0;
            A         <= '0;
            B         <= '0;
            operator  <= 2'b00;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (!STICKY_ERR) begin
                cmd_err <= 1'b0;
            end

            if (data_valid || state == S_IDLE) begin
                tcnt <= '0;
            end else if (tcnt != T_LAST) begin
                tcnt <= tcnt + TW'(1);
            end

            if (tmo_hit) begin
                state   <= S_IDLE;
                cmd_err <= 1'b1;
            end else if (data_valid && !is_skip) begin
                case (state)
                    S_IDLE: begin
                        if (is_digit) begin
                            acc_a <= {4'b0, value[3:0]};
                            cnt_a <= CW'(1);
                            acc_b <= '0;
                            cnt_b <= '0;
                            state <= S_A;
                        end else if (!is_term) begin
                            state <= S_ERR;
                        end
                    end
                    S_A: begin
                        if (is_digit) begin
                            if (a_ok) begin
                                acc_a <= prod_a[7:0];
                                cnt_a <= cnt_a + CW'(1);
                            end else begin
                                state <= S_ERR;
                            end
                        end else if (is_op) begin
                            op_pend <= op_code;
                            acc_b   <= '0;
                            cnt_b   <= '0;
                            state   <= S_B;
                        end else if (is_term) begin
                            // The terminator that breaks the command also ends it
                            cmd_err <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            if (b_ok) begin
                                acc_b <= prod_b[7:0];
                                cnt_b <= cnt_b + CW'(1);
                            end else begin
                                state <= S_ERR;
                            end
                        end else if (is_term) begin
                            if (cnt_b != '0) begin
                                A         <= acc_a;
                                B         <= acc_b;
                                operator  <= op_pend;
                                cmd_valid <= 1'b1;
                                cmd_err   <= 1'b0;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                    default: begin
                        if (is_term) begin
                            cmd_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_parser.sv
// tb/tb_alu_cmd_parser.sv - scoreboard bench for alu_cmd_parser
module tb_alu_cmd_parser;

`ifdef ALU_CMD_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       data_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [1:0] operator;
    logic       cmd_valid;
    logic       cmd_err;
    logic       busy;

    typedef struct {
        bit         err;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
    } ev_t;

    ev_t        sb[$];
    ev_t        ev;
    logic [7:0] last_a;
    logic [7:0] last_b;
    logic [1:0] last_op;
    bit         err_lvl;
    bit         err_q;
    bit         prev_lvl;
    int         n_tests;
    int         n_fail;

    alu_cmd_parser #(
        .MAX_DIGITS     (3),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .data_valid (data_valid),
        .A          (A),
        .B          (B),
        .operator   (operator),
        .cmd_valid  (cmd_valid),
        .cmd_err    (cmd_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            value      = s[i];
            data_valid = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
        value      = 8'h00;
    endtask

    task automatic expect_event(input bit is_err, input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] op);
        ev_t e;
        e.err = is_err;
        e.a   = a;
        e.b   = b;
        e.op  = op;
        // A held sticky level produces no new rising edge for a repeated error
        if (!(is_err && STICKY && err_lvl)) begin
            sb.push_back(e);
        end
        err_lvl = is_err;
    endtask

    task automatic cmd(input string s, input bit is_err, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op);
        expect_event(is_err, a, b, op);
        send_str(s);
        check({"busy_after ", s}, busy, 0);
        @(negedge clk);
        check({"valid_width ", s}, cmd_valid, 0);
        check({"err_after ", s}, cmd_err, STICKY ? err_lvl : 1'b0);
    endtask

    // Scoreboard monitor: pops one expectation per cmd_valid pulse or cmd_err rising edge
    always @(negedge clk) begin
        if (!rst) begin
            err_q = 1'b0;
        end else begin
            if (cmd_valid || (cmd_err && !err_q)) begin
                check("valid_err_excl", cmd_valid & cmd_err, 0);
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    ev = sb.pop_front();
                    check("event_kind", cmd_err, ev.err);
                    if (ev.err) begin
                        check("held_A", A, last_a);
                        check("held_B", B, last_b);
                        check("held_op", operator, last_op);
                    end else begin
                        check("commit_A", A, ev.a);
                        check("commit_B", B, ev.b);
                        check("commit_op", operator, ev.op);
                        last_a  = ev.a;
                        last_b  = ev.b;
                        last_op = ev.op;
                    end
                end
            end
            err_q = cmd_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        last_a     = 8'd0;
        last_b     = 8'd0;
        last_op    = 2'd0;
        err_lvl    = 1'b0;
        err_q      = 1'b0;
        rst        = 1'b0;
        value      = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_op", operator, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_err", cmd_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);

        cmd("12+34=",   1'b0, 8'd12,  8'd34, 2'b00);
        cmd("255*2\r",  1'b0, 8'd255, 8'd2,  2'b10);
        cmd("9-3=",     1'b0, 8'd9,   8'd3,  2'b01);
        cmd("12+34=",   1'b0, 8'd12,  8'd34, 2'b00);
        cmd("256+1=",   1'b1, 8'd0,   8'd0,  2'b00);
        cmd("1234+1=",  1'b1, 8'd0,   8'd0,  2'b00);
        cmd(" 7 / 0 =", 1'b0, 8'd7,   8'd0,  2'b11);
        cmd("5+=",      1'b1, 8'd0,   8'd0,  2'b00);
        cmd("+3=",      1'b1, 8'd0,   8'd0,  2'b00);
        cmd("007+255=", 1'b0, 8'd7,   8'd255, 2'b00);
        cmd("0007+1=",  1'b1, 8'd0,   8'd0,  2'b00);
        cmd("\n=5*5\n=", 1'b0, 8'd5,  8'd5,  2'b10);
        cmd("12=",      1'b1, 8'd0,   8'd0,  2'b00);
        cmd("1+2x=",    1'b1, 8'd0,   8'd0,  2'b00);
        cmd("1+256=",   1'b1, 8'd0,   8'd0,  2'b00);

        prev_lvl = err_lvl;
        expect_event(1'b1, 8'd0, 8'd0, 2'b00);
        send_str("5+");
        repeat (99) @(negedge clk);
        check("tmo_early", cmd_err, STICKY ? prev_lvl : 1'b0);
        check("tmo_busy_before", busy, 1);
        @(negedge clk);
        check("tmo_fire", cmd_err, 1);
        check("tmo_busy_after", busy, 0);
        @(negedge clk);
        cmd("1-1=",     1'b0, 8'd1,   8'd1,  2'b01);

        send_str("12+");
        check("partial_busy", busy, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_A", A, 0);
        check("mid_rst_B", B, 0);
        check("mid_rst_op", operator, 0);
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_err", cmd_err, 0);
        check("mid_rst_busy", busy, 0);
        last_a  = 8'd0;
        last_b  = 8'd0;
        last_op = 2'd0;
        err_lvl = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        cmd("3*4=",     1'b0, 8'd3,   8'd4,  2'b10);

        cmd("256+1=",   1'b1, 8'd0,   8'd0,  2'b00);
        cmd("1234+1=",  1'b1, 8'd0,   8'd0,  2'b00);
        cmd("12+34=",   1'b0, 8'd12,  8'd34, 2'b00);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
